// File: rtl/udp_parser.sv
// UDP datagram parser: strips the 8-byte UDP header from an IP payload byte
// stream, filters on destination port and forwards the payload bytes with
// start/end/error framing pulses. All outputs are registered one clock after
// the input byte that caused them.
module udp_parser #(
  parameter logic [15:0] UDP_PORT = 16'd5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ip_data_in,
  input  logic        ip_byte_valid,
  input  logic        ip_eof,
  input  logic        ip_err,
  output logic [7:0]  udp_data_out,
  output logic        udp_byte_valid,
  output logic        udp_sof,
  output logic        udp_eof,
  output logic        udp_err,
  output logic [15:0] udp_src_port,
  output logic [15:0] udp_len
);

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PAYLOAD = 2'd1,
    TRAIL   = 2'd2,
    DROP    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_hdr_cnt;
  logic [2:0]  w_hdr_cnt_nxt;
  logic [15:0] r_remaining;
  logic [15:0] w_remaining_nxt;
  logic [15:0] r_src_shadow;
  logic [15:0] w_src_shadow_nxt;
  logic [7:0]  r_dst_hi;
  logic [7:0]  w_dst_hi_nxt;
  logic [7:0]  r_len_hi;
  logic [7:0]  w_len_hi_nxt;
  logic [15:0] r_len_shadow;
  logic [15:0] w_len_shadow_nxt;
  logic        r_first;
  logic        w_first_nxt;

  logic [7:0]  w_data_nxt;
  logic        w_valid_nxt;
  logic        w_sof_nxt;
  logic        w_eof_nxt;
  logic        w_err_nxt;
  logic [15:0] w_src_port_nxt;
  logic [15:0] w_len_nxt;

  logic [15:0] w_dst_port;
  logic [15:0] w_len_field;
  logic [15:0] w_rem_dec;

  // Header fields assembled from the stored high byte and the byte on the bus.
  assign w_dst_port  = {r_dst_hi, ip_data_in};
  assign w_len_field = {r_len_hi, ip_data_in};
  assign w_rem_dec   = r_remaining - 16'd1;

  // State, counters, header shadows and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= HEADER;
      r_hdr_cnt      <= 3'd0;
      r_remaining    <= 16'd0;
      r_src_shadow   <= 16'd0;
      r_dst_hi       <= 8'h00;
      r_len_hi       <= 8'h00;
      r_len_shadow   <= 16'd0;
      r_first        <= 1'b0;
      udp_data_out   <= 8'h00;
      udp_byte_valid <= 1'b0;
      udp_sof        <= 1'b0;
      udp_eof        <= 1'b0;
      udp_err        <= 1'b0;
      udp_src_port   <= 16'd0;
      udp_len        <= 16'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_hdr_cnt      <= w_hdr_cnt_nxt;
      r_remaining    <= w_remaining_nxt;
      r_src_shadow   <= w_src_shadow_nxt;
      r_dst_hi       <= w_dst_hi_nxt;
      r_len_hi       <= w_len_hi_nxt;
      r_len_shadow   <= w_len_shadow_nxt;
      r_first        <= w_first_nxt;
      udp_data_out   <= w_data_nxt;
      udp_byte_valid <= w_valid_nxt;
      udp_sof        <= w_sof_nxt;
      udp_eof        <= w_eof_nxt;
      udp_err        <= w_err_nxt;
      udp_src_port   <= w_src_port_nxt;
      udp_len        <= w_len_nxt;
    end
  end

  // Next-state and next-output decode; only qualified input bytes move anything.
  always_comb begin
    w_state_nxt      = r_state;
    w_hdr_cnt_nxt    = r_hdr_cnt;
    w_remaining_nxt  = r_remaining;
    w_src_shadow_nxt = r_src_shadow;
    w_dst_hi_nxt     = r_dst_hi;
    w_len_hi_nxt     = r_len_hi;
    w_len_shadow_nxt = r_len_shadow;
    w_first_nxt      = r_first;
    w_data_nxt       = udp_data_out;
    w_valid_nxt      = 1'b0;
    w_sof_nxt        = 1'b0;
    w_eof_nxt        = 1'b0;
    w_err_nxt        = 1'b0;
    w_src_port_nxt   = udp_src_port;
    w_len_nxt        = udp_len;

    if (ip_byte_valid) begin
      case (r_state)
        HEADER: begin
          w_hdr_cnt_nxt = r_hdr_cnt + 3'd1;
          case (r_hdr_cnt)
            3'd0:    w_src_shadow_nxt[15:8] = ip_data_in;
            3'd1:    w_src_shadow_nxt[7:0]  = ip_data_in;
            3'd2:    w_dst_hi_nxt           = ip_data_in;
            3'd4:    w_len_hi_nxt           = ip_data_in;
            3'd5:    w_len_shadow_nxt       = w_len_field;
            default: ;
          endcase

          if (ip_eof) begin
            w_hdr_cnt_nxt = 3'd0;
            if (r_hdr_cnt == 3'd7) begin
              // Exactly eight bytes: header-only datagram ends here.
              w_src_port_nxt = r_src_shadow;
              w_len_nxt      = r_len_shadow;
              w_eof_nxt      = 1'b1;
              w_err_nxt      = ip_err || (r_len_shadow != 16'd8);
            end else begin
              w_err_nxt = 1'b1;
            end
          end else if ((r_hdr_cnt == 3'd3) && (w_dst_port != UDP_PORT)) begin
            w_err_nxt     = 1'b1;
            w_hdr_cnt_nxt = 3'd0;
            w_state_nxt   = DROP;
          end else if ((r_hdr_cnt == 3'd5) && (w_len_field < 16'd8)) begin
            w_err_nxt     = 1'b1;
            w_hdr_cnt_nxt = 3'd0;
            w_state_nxt   = DROP;
          end else if (r_hdr_cnt == 3'd7) begin
            w_src_port_nxt  = r_src_shadow;
            w_len_nxt       = r_len_shadow;
            w_remaining_nxt = r_len_shadow - 16'd8;
            w_first_nxt     = 1'b1;
            w_hdr_cnt_nxt   = 3'd0;
            w_state_nxt     = (r_len_shadow != 16'd8) ? PAYLOAD : TRAIL;
          end
        end

        PAYLOAD: begin
          if (ip_eof && ip_err) begin
            w_eof_nxt   = 1'b1;
            w_err_nxt   = 1'b1;
            w_state_nxt = HEADER;
          end else begin
            w_valid_nxt     = 1'b1;
            w_data_nxt      = ip_data_in;
            w_sof_nxt       = r_first;
            w_first_nxt     = 1'b0;
            w_remaining_nxt = w_rem_dec;
            if (ip_eof) begin
              // Early end of frame means the datagram was truncated.
              w_eof_nxt   = 1'b1;
              w_err_nxt   = (w_rem_dec != 16'd0);
              w_state_nxt = HEADER;
            end else if (w_rem_dec == 16'd0) begin
              w_state_nxt = TRAIL;
            end
          end
        end

        TRAIL: begin
          if (ip_eof) begin
            w_eof_nxt   = 1'b1;
            w_err_nxt   = ip_err;
            w_state_nxt = HEADER;
          end
        end

        DROP: begin
          if (ip_eof) begin
            w_hdr_cnt_nxt = 3'd0;
            w_state_nxt   = HEADER;
          end
        end

        default: begin
          w_hdr_cnt_nxt = 3'd0;
          w_state_nxt   = HEADER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_parser.sv
// Directed, table-driven bench for udp_parser with hand-computed expectations.
module tb_udp_parser;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       eof;
    logic       err;
    logic       ev;
    logic [7:0] ed;
    logic       es;
    logic       ee;
    logic       eerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ip_data_in;
  logic        ip_byte_valid;
  logic        ip_eof;
  logic        ip_err;
  logic [7:0]  udp_data_out;
  logic        udp_byte_valid;
  logic        udp_sof;
  logic        udp_eof;
  logic        udp_err;
  logic [15:0] udp_src_port;
  logic [15:0] udp_len;

  int compared   = 0;
  int mismatched = 0;
  int vecIndex   = 0;
  vec_t vecQ[$];

  udp_parser #(.UDP_PORT(16'd5000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ip_data_in    (ip_data_in),
    .ip_byte_valid (ip_byte_valid),
    .ip_eof        (ip_eof),
    .ip_err        (ip_err),
    .udp_data_out  (udp_data_out),
    .udp_byte_valid(udp_byte_valid),
    .udp_sof       (udp_sof),
    .udp_eof       (udp_eof),
    .udp_err       (udp_err),
    .udp_src_port  (udp_src_port),
    .udp_len       (udp_len)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Queue one input byte together with the outputs expected one clock later.
  task automatic addVec(input logic v, input logic [7:0] d, input logic eof,
                        input logic err, input logic ev, input logic [7:0] ed,
                        input logic es, input logic ee, input logic eerr);
    vec_t t;
    t.v = v; t.d = d; t.eof = eof; t.err = err;
    t.ev = ev; t.ed = ed; t.es = es; t.ee = ee; t.eerr = eerr;
    vecQ.push_back(t);
  endtask

  // Queue the eight header bytes; errAt marks the byte expected to raise udp_err.
  task automatic addHdr(input logic [15:0] src, input logic [15:0] dst,
                        input logic [15:0] len, input int errAt);
    logic [7:0] b[8];
    b[0] = src[15:8]; b[1] = src[7:0];
    b[2] = dst[15:8]; b[3] = dst[7:0];
    b[4] = len[15:8]; b[5] = len[7:0];
    b[6] = 8'h00;     b[7] = 8'h00;
    for (int i = 0; i < 8; i++)
      addVec(1'b1, b[i], 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, (i == errAt));
  endtask

  // Drive one byte and wait until its registered response is visible.
  task automatic applyStimulus(input vec_t t);
    ip_byte_valid = t.v;
    ip_data_in    = t.d;
    ip_eof        = t.eof;
    ip_err        = t.err;
    @(posedge clk);
    #1;
    ip_byte_valid = 1'b0;
    ip_eof        = 1'b0;
    ip_err        = 1'b0;
  endtask

  // Compare the framing flags and, when a byte is expected, its data.
  task automatic checkOutput(input string name, input vec_t t);
    logic [11:0] act;
    logic [11:0] exp;
    exp = {t.ev, t.es, t.ee, t.eerr, (t.ev ? t.ed : 8'h00)};
    act = {udp_byte_valid, udp_sof, udp_eof, udp_err, (t.ev ? udp_data_out : 8'h00)};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got valid/sof/eof/err/data=%h, expected %h", name, act, exp);
    end
  endtask

  // Generic value comparison used for port fields and reset values.
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply and check every queued vector, then empty the table.
  task automatic runTable(input string tag);
    foreach (vecQ[i]) begin
      applyStimulus(vecQ[i]);
      checkOutput($sformatf("%s_vec%0d", tag, vecIndex), vecQ[i]);
      vecIndex++;
    end
    vecQ.delete();
  endtask

  // Latched header fields of the most recent accepted datagram.
  task automatic checkPorts(input string tag, input logic [15:0] src, input logic [15:0] len);
    checkVal({tag, "_src_port"}, {16'h0, udp_src_port}, {16'h0, src});
    checkVal({tag, "_len"}, {16'h0, udp_len}, {16'h0, len});
  endtask

  // All outputs at their reset values.
  task automatic checkResetState(input string tag);
    checkVal({tag, "_flags"}, {28'h0, udp_byte_valid, udp_sof, udp_eof, udp_err}, 32'h0);
    checkVal({tag, "_data"}, {24'h0, udp_data_out}, 32'h0);
    checkPorts(tag, 16'h0000, 16'h0000);
  endtask

  initial begin
    rst_n         = 1'b0;
    ip_data_in    = 8'h00;
    ip_byte_valid = 1'b0;
    ip_eof        = 1'b0;
    ip_err        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good datagram; ip_err without eof and an idle gap must both be ignored.
    addHdr(16'h1234, 16'd5000, 16'd12, -1);
    addVec(1'b1, 8'hDE, 1'b0, 1'b0, 1'b1, 8'hDE, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 8'hAD, 1'b0, 1'b1, 1'b1, 8'hAD, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'hBE, 1'b0, 1'b0, 1'b1, 8'hBE, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'hEF, 1'b1, 1'b0, 1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
    addVec(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    runTable("good");
    checkPorts("good", 16'h1234, 16'd12);

    // Wrong destination port: one error pulse after byte 3, then silence.
    addHdr(16'h1234, 16'd5001, 16'd12, 3);
    addVec(1'b1, 8'hDE, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'hAD, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'hBE, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'hEF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    runTable("badport");
    checkPorts("badport", 16'h1234, 16'd12);

    // Two payload bytes followed by padding; eof arrives with the last pad.
    addHdr(16'h0042, 16'd5000, 16'd10, -1);
    addVec(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    runTable("padded");
    checkPorts("padded", 16'h0042, 16'd10);

    // Truncated datagram, then an upstream error on the eof byte.
    addHdr(16'h1111, 16'd5000, 16'd12, -1);
    addVec(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1);
    addHdr(16'h2222, 16'd5000, 16'd12, -1);
    addVec(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    runTable("trunc");
    checkPorts("trunc", 16'h2222, 16'd12);

    // Short length field, eof inside the header, then a header-only datagram.
    addHdr(16'h0007, 16'd5000, 16'd5, 5);
    addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    addHdr(16'h0009, 16'd5000, 16'd8, -1);
    addVec(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    runTable("short");
    checkPorts("short", 16'h0009, 16'd8);

    // Reset in the middle of a payload, then a clean datagram.
    addHdr(16'hABCD, 16'd5000, 16'd12, -1);
    addVec(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    runTable("prereset");
    checkPorts("prereset", 16'hABCD, 16'd12);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    addHdr(16'h1234, 16'd5000, 16'd12, -1);
    addVec(1'b1, 8'hDE, 1'b0, 1'b0, 1'b1, 8'hDE, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 8'hAD, 1'b0, 1'b0, 1'b1, 8'hAD, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'hBE, 1'b0, 1'b0, 1'b1, 8'hBE, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 8'hEF, 1'b1, 1'b0, 1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
    runTable("postreset");
    checkPorts("postreset", 16'h1234, 16'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/udp_parser.md
UDP_PARSER -- requirements
Module: udp_parser

Interface
REQ-001 SHALL have parameter UDP_PORT, default 16'd5000, the accepted destination port.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ip_data_in  input  8  IP payload byte.
REQ-005 SHALL have port ip_byte_valid  input  1  ip_data_in/ip_eof/ip_err qualifier.
REQ-006 SHALL have port ip_eof  input  1  last byte of IP payload; qualified by ip_byte_valid.
REQ-007 SHALL have port ip_err  input  1  upstream frame error; meaningful only with ip_byte_valid && ip_eof.
REQ-008 SHALL have port udp_data_out  output  8  UDP payload byte.
REQ-009 SHALL have port udp_byte_valid  output  1  udp_data_out valid, one-cycle pulse per byte.
REQ-010 SHALL have port udp_sof  output  1  pulse with first payload byte.
REQ-011 SHALL have port udp_eof  output  1  end-of-datagram pulse.
REQ-012 SHALL have port udp_err  output  1  datagram error pulse.
REQ-013 SHALL have port udp_src_port  output  16  source port of current datagram.
REQ-014 SHALL have port udp_len  output  16  UDP length field of current datagram.

Function
REQ-015 SHALL implement states HEADER, PAYLOAD, TRAIL, DROP; only ip_byte_valid cycles advance state or counters.
REQ-016 SHALL count header bytes 0..7 with a 3-bit counter: bytes 0-1 source port, 2-3 destination port, 4-5 length, 6-7 checksum (ignored); all fields big-endian.
REQ-017 SHALL, at header byte 3, compare {byte2,byte3} to UDP_PORT; mismatch -> udp_err pulse, go DROP.
REQ-018 SHALL, at header byte 5, treat length < 8 as error -> udp_err pulse, go DROP.
REQ-019 SHALL, at header byte 7, latch udp_src_port and udp_len (held stable until the next datagram's byte 7), load 16-bit remaining = length - 8, go PAYLOAD if remaining != 0, else TRAIL.
REQ-020 SHALL register all outputs: response appears exactly 1 clk after the accepting ip_byte_valid cycle.
REQ-021 SHALL, in PAYLOAD, forward each byte (udp_byte_valid=1, udp_data_out=ip_data_in) and decrement remaining; udp_sof=1 on the first payload byte only.
REQ-022 SHALL, in PAYLOAD, go TRAIL after the byte that brings remaining to 0; bytes arriving in TRAIL (IP/Ethernet padding) are discarded.
REQ-023 SHALL, on ip_eof with ip_err=0 in PAYLOAD: forward that byte; if remaining after it != 0 (truncated datagram) pulse udp_eof and udp_err, else pulse udp_eof only; go HEADER.
REQ-024 SHALL, on ip_eof with ip_err=0 in TRAIL, pulse udp_eof (udp_byte_valid=0); go HEADER.
REQ-025 SHALL, on ip_eof with ip_err=1 in PAYLOAD or TRAIL, not forward the byte and pulse udp_eof and udp_err together; go HEADER.
REQ-026 SHALL, on ip_eof in HEADER (datagram < 8 bytes), pulse udp_err only (no udp_eof); reset header counter; stay HEADER.
REQ-027 SHALL, in DROP, emit nothing and return to HEADER with header counter 0 on ip_eof; the error pulse of REQ-017/018 is the only output for a dropped datagram.
REQ-028 SHALL ignore ip_err when not accompanied by ip_byte_valid && ip_eof.
REQ-029 SHALL emit exactly one udp_eof per datagram passing REQ-017/018, and udp_sof only when length > 8.

Reset
REQ-030 SHALL, while rst_n=0, force state HEADER, header counter 0, remaining 0, udp_byte_valid/udp_sof/udp_eof/udp_err 0, udp_data_out 8'h00, udp_src_port 0, udp_len 0.
REQ-031 SHALL, on reset mid-datagram, discard the partial datagram; next ip_byte_valid byte after release is header byte 0.

Verification
REQ-032 Datagram src 0x1234, dst 5000, len 12, payload DE AD BE EF, ip_eof on 0xEF -> 4 valid bytes, sof with 0xDE, eof with 0xEF, udp_src_port=0x1234, udp_len=12, no err.
REQ-033 Same with dst 5001 -> single udp_err pulse 1 clk after byte 3, no valid/sof/eof until next datagram parses correctly.
REQ-034 len 10, payload AA BB then 6 padding bytes, ip_eof on last pad -> 2 valid bytes, udp_eof on the cycle after last pad with valid=0, no err.
REQ-035 len 12, ip_eof on 2nd payload byte -> 2 valid bytes, udp_eof+udp_err with the 2nd byte; ip_err=1 on eof byte -> that byte not forwarded, eof+err.
REQ-036 Length field 0x0005 -> udp_err after byte 5, DROP until ip_eof; ip_eof at header byte 4 -> udp_err only; rst_n pulse mid-payload -> outputs 0, next frame parses cleanly.
